rf_dump_reader: RTL and testbench

Debug read-out engine for the 32x32 register file (`REG_FILE`) of the single-cycle RISC-V core. On a start pulse it drives the register file's two read ports, `A1`/`A2`, to walk every register in ascending order. It streams each value with its index over a valid/ready handshake and reports a running XOR checksum at completion. It sits beside the core and shares the register file's read ports through a debug mux outside this block.

---
 rtl/rf_dump_pkg.sv | 16 +
 rtl/rf_dump_reader.sv | 139 +++++++++++++
 tb/tb_rf_dump_reader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_pkg.sv
// Shared types and default sizing for the register-file dump reader.
package rf_dump_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DRAIN0 = 3'd2,
        DRAIN1 = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;

endpackage

// File: rtl/rf_dump_reader.sv
// Walks the register file two registers at a time and streams {out_idx, out_data}, XOR-accumulating a checksum.
// Latency: first word 2 cycles after start; 3 cycles per pair with out_ready held high.
// Backpressure: out_ready low freezes out_data/out_idx/checksum and pauses the walk.
module rf_dump_reader
    import rf_dump_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_a1,
    output logic [ADDR_W-1:0] rf_a2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_FETCH  = 3'(FETCH);
    localparam logic [2:0] S_DRAIN0 = 3'(DRAIN0);
    localparam logic [2:0] S_DRAIN1 = 3'(DRAIN1);
    localparam logic [2:0] S_DONE   = 3'(DONE);

    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TWO    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_THREE  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 2);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_a1;
    logic [ADDR_W-1:0] r_a2;
    logic [ADDR_W-1:0] r_out_idx;
    logic [DATA_W-1:0] r_buf1;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] r_checksum;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;
    logic              w_accept;

    assign w_accept = r_out_valid & out_ready;

    // r_out_data doubles as the even-register buffer; r_buf1 parks the odd one.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_a1        <= '0;
            r_a2        <= '0;
            r_out_idx   <= '0;
            r_buf1      <= '0;
            r_out_data  <= '0;
            r_checksum  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept)
                r_checksum <= r_checksum ^ r_out_data;
            if (abort && (r_state != S_IDLE)) begin
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state    <= S_FETCH;
                            r_ptr      <= '0;
                            r_checksum <= '0;
                            r_a1       <= '0;
                            r_a2       <= A_ONE;
                            r_busy     <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        r_out_data  <= rf_rd1;
                        r_buf1      <= rf_rd2;
                        r_out_idx   <= r_ptr;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DRAIN0;
                    end
                    S_DRAIN0: begin
                        if (out_ready) begin
                            r_out_data <= r_buf1;
                            r_out_idx  <= r_ptr + A_ONE;
                            r_state    <= S_DRAIN1;
                        end
                    end
                    S_DRAIN1: begin
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                            if (r_ptr == LAST_PTR) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_ptr   <= r_ptr + A_TWO;
                                r_a1    <= r_ptr + A_TWO;
                                r_a2    <= r_ptr + A_THREE;
                                r_state <= S_FETCH;
                            end
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rf_a1     = r_a1;
    assign rf_a2     = r_a2;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign checksum  = r_checksum;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Self-checking bench for rf_dump_reader with a behavioural register file and snapshot model.
module tb_rf_dump_reader;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic        abort;
    logic        out_ready;
    logic [4:0]  rf_a1, rf_a2, out_idx;
    logic [31:0] rf_rd1, rf_rd2, out_data, checksum;
    logic        out_valid, busy, done;

    logic [31:0] rf [N];
    int nchk  = 0;
    int npass = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    assign rf_rd1 = rf[rf_a1];
    assign rf_rd2 = rf[rf_a2];

    rf_dump_reader #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .RST       (RST),
        .start     (start),
        .abort     (abort),
        .rf_a1     (rf_a1),
        .rf_a2     (rf_a2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload_ramp();
        for (int i = 0; i < N; i++) rf[i] = 32'(i * 16 + 15);
        rf[0] = 32'd0;
    endtask

    task automatic preload_rand();
        for (int i = 0; i < N; i++) rf[i] = $urandom;
    endtask

    // rmode: 0 ready high, 1 ready toggling, 2 ready random.
    task automatic run_dump(input int rmode, input int abort_word, input bit mid_start, input bit do_write);
        logic [31:0] exp_v [N];
        logic [31:0] got_d [$];
        logic [4:0]  got_i [$];
        logic [31:0] ref_sum, sum_at_done, prev_d, prev_s;
        logic [4:0]  prev_i;
        int  nacc, done_cyc, n_exp, wp, cyc;
        bit  fin, aborted, wrote, prev_stall, toggle, saw_done;
        nacc = 0; done_cyc = -1; fin = 0; aborted = 0; wrote = 0;
        prev_stall = 0; toggle = 1; saw_done = 0; sum_at_done = '0;
        prev_d = '0; prev_s = '0; prev_i = '0;
        for (int i = 0; i < N; i++) exp_v[i] = rf[i];

        start = 1'b1; abort = 1'b0;
        tick();
        start = 1'b0;
        cyc = 1;
        chk("busy_c1", 32'(busy), 32'd1);
        chk("sum_clr", checksum, 32'd0);
        chk("a1_c1", 32'(rf_a1), 32'd0);
        chk("a2_c1", 32'(rf_a2), 32'd1);

        while (!fin && cyc < 600) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = toggle; toggle = !toggle; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            chk("busy_hi", 32'(busy), 32'd1);
            if (prev_stall) begin
                chk("stall_data", out_data, prev_d);
                chk("stall_idx", 32'(out_idx), 32'(prev_i));
                chk("stall_sum", checksum, prev_s);
            end
            if (busy && !out_valid && !done) begin
                chk("a1_fetch", 32'(rf_a1), 32'(nacc));
                chk("a2_fetch", 32'(rf_a2), 32'(nacc + 1));
            end
            if (done) begin
                done_cyc    = cyc;
                sum_at_done = checksum;
                saw_done    = 1;
                fin         = 1;
            end
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_i.push_back(out_idx);
                nacc++;
                if (nacc - 1 == abort_word) abort = 1'b1;
            end
            // Pairs already on the output were snapshotted; later pairs see the write.
            if (do_write && !wrote && out_valid && out_idx == 5'd4) begin
                wrote = 1;
                wp = int'(out_idx) / 2;
                rf[5] = 32'd60;
                rf[6] = 32'd60;
                if (5 / 2 > wp) exp_v[5] = 32'd60;
                if (6 / 2 > wp) exp_v[6] = 32'd60;
            end
            if (mid_start && cyc == 20) start = 1'b1;
            prev_stall = out_valid && !out_ready;
            prev_d = out_data; prev_i = out_idx; prev_s = checksum;
            tick();
            cyc++;
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                aborted = 1;
                fin = 1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_vld", 32'(out_valid), 32'd0);
            end
        end
        chk("finished", 32'(fin), 32'd1);

        if (saw_done) begin
            chk("done_pulse", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        n_exp = aborted ? abort_word + 1 : N;
        chk("nwords", 32'(got_i.size()), 32'(n_exp));
        for (int i = 0; i < n_exp && i < got_i.size(); i++) begin
            chk("word_idx", 32'(got_i[i]), 32'(i));
            chk("word_dat", got_d[i], exp_v[i]);
        end
        ref_sum = '0;
        for (int i = 0; i < n_exp; i++) ref_sum ^= exp_v[i];
        if (aborted) begin
            for (int k = 0; k < 3; k++) begin
                chk("abort_nodone", 32'(done), 32'd0);
                chk("abort_sum", checksum, ref_sum);
                tick();
            end
        end else begin
            chk("done_sum", sum_at_done, ref_sum);
            if (rmode == 0) chk("done_cyc", 32'(done_cyc), 32'd49);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        preload_ramp();
        tick();
        tick();
        RST = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_sum",   checksum, 32'd0);
        chk("rst_a1",    32'(rf_a1), 32'd0);
        chk("rst_a2",    32'(rf_a2), 32'd0);
        chk("rst_data",  out_data, 32'd0);
        chk("rst_idx",   32'(out_idx), 32'd0);
        tick();

        preload_ramp();
        run_dump(0, -1, 0, 0);
        run_dump(1, -1, 0, 0);
        run_dump(2, -1, 0, 1);

        preload_rand();
        run_dump(0, 9, 0, 0);

        preload_rand();
        run_dump(2, -1, 1, 0);
        run_dump(0, -1, 0, 0);

        // Reset while stalled in DRAIN1, then a full dump.
        preload_ramp();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100 && !(out_valid && out_idx == 5'd7); k++) begin
            out_ready = 1'b1;
            tick();
        end
        chk("pre_rst_idx", 32'(out_idx), 32'd7);
        out_ready = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy",  32'(busy), 32'd0);
        chk("mrst_done",  32'(done), 32'd0);
        chk("mrst_sum",   checksum, 32'd0);
        chk("mrst_a1",    32'(rf_a1), 32'd0);
        chk("mrst_a2",    32'(rf_a2), 32'd0);
        chk("mrst_data",  out_data, 32'd0);
        chk("mrst_idx",   32'(out_idx), 32'd0);
        run_dump(0, -1, 0, 0);

        for (int r = 0; r < 2; r++) begin
            preload_rand();
            run_dump(2, -1, 0, 0);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
